// File: rtl/arb8_rr_ctrl_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The master side drives requests and enable; the slave side returns the grant.
interface arb8_rr_ctrl_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/arb8_rr_ctrl.sv
// Round-robin arbiter for eight requesters with bounded hold time.
// Drives both the encoded winner index and its one-hot decode.
module arb8_rr_ctrl #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic           clk,
  input  logic           rst,
  arb8_rr_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  logic [7:0] rot_req;
  logic [2:0] pick_off;
  logic [2:0] pick_idx;
  logic       pick_found;

  // Rotate so that bit 0 is the ptr requester, then take the lowest set bit.
  always_comb begin
    rot_req    = 8'({bus.req, bus.req} >> ptr_q);
    pick_off   = 3'd0;
    pick_found = |bus.req;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) begin
        pick_off = 3'(i);
      end
    end
    pick_idx = ptr_q + pick_off;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && pick_found) begin
          gnt_id_d   = pick_idx;
          hold_cnt_d = 8'd1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // Voluntary release wins over the hold limit on the same edge.
        if (!bus.req[gnt_id_q]) begin
          state_d = IDLE;
          ptr_d   = gnt_id_q + 3'd1;
        end else if (hold_cnt_q == HOLD_MAX_C) begin
          state_d   = IDLE;
          ptr_d     = gnt_id_q + 3'd1;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      gnt_id_q   <= 3'd0;
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt_valid = (state_q == BUSY);
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;
  assign bus.gnt       = (state_q == BUSY) ? (8'd1 << gnt_id_q) : 8'd0;

endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// Three arbiters (HOLD_MAX 16, 3, 1) share one stimulus stream and are
// compared every cycle against a queue-free behavioural model of the rules.
module tb_arb8_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_s = 8'h00;
  logic       en_s = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  arb8_rr_ctrl_if if0 ();
  arb8_rr_ctrl_if if1 ();
  arb8_rr_ctrl_if if2 ();

  assign if0.req = req_s;
  assign if0.en  = en_s;
  assign if1.req = req_s;
  assign if1.en  = en_s;
  assign if2.req = req_s;
  assign if2.en  = en_s;

  arb8_rr_ctrl #(.HOLD_MAX(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  arb8_rr_ctrl #(.HOLD_MAX(3))  u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  arb8_rr_ctrl #(.HOLD_MAX(1))  u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  logic [12:0] dut_out [3];
  assign dut_out[0] = {if0.gnt, if0.gnt_id, if0.gnt_valid, if0.timeout};
  assign dut_out[1] = {if1.gnt, if1.gnt_id, if1.gnt_valid, if1.timeout};
  assign dut_out[2] = {if2.gnt, if2.gnt_id, if2.gnt_valid, if2.timeout};

  // Behavioural model: who owns the resource, for how long, and where the
  // rotation resumes next.
  int hold_max [3] = '{16, 3, 1};
  int m_busy   [3];
  int m_owner  [3];
  int m_next   [3];
  int m_held   [3];
  int m_to     [3];

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_busy[d]  = 0;
        m_owner[d] = 0;
        m_next[d]  = 0;
        m_held[d]  = 0;
        m_to[d]    = 0;
      end else begin
        m_to[d] = 0;
        if (m_busy[d] != 0) begin
          if (!req_s[m_owner[d]]) begin
            m_busy[d] = 0;
            m_next[d] = (m_owner[d] + 1) % 8;
          end else if (m_held[d] == hold_max[d]) begin
            m_busy[d] = 0;
            m_next[d] = (m_owner[d] + 1) % 8;
            m_to[d]   = 1;
          end else begin
            m_held[d] = m_held[d] + 1;
          end
        end else if (en_s && req_s != 8'h00) begin
          for (int k = 7; k >= 0; k--) begin
            if (req_s[(m_next[d] + k) % 8]) begin
              m_owner[d] = (m_next[d] + k) % 8;
            end
          end
          m_busy[d] = 1;
          m_held[d] = 1;
        end
      end
    end
  end

  function automatic logic [12:0] modelOut(input int d);
    logic [7:0] g;
    g = (m_busy[d] != 0) ? (8'h01 << m_owner[d]) : 8'h00;
    return {g, 3'(m_owner[d]), (m_busy[d] != 0), (m_to[d] != 0)};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("dut%0d_cycle", d), 16'(dut_out[d]), 16'(modelOut(d)));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] r, input logic e);
    req_s = r;
    en_s  = e;
    @(negedge clk);
  endtask

  task automatic resetPulse();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("dut%0d_async_reset", d), 16'(dut_out[d]), 16'h0000);
    end
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  logic [7:0] exp_to_g [9] = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h00, 8'h01};
  logic       exp_to_t [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] rv;
  logic [7:0] one_hot;

  initial begin
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h00, 1'b1);
      checkOutput("idle_after_reset", 16'(dut_out[0]), 16'h0000);
    end

    applyStimulus(8'h20, 1'b1);
    checkOutput("single_gnt", 16'(if0.gnt), 16'h0020);
    checkOutput("single_gnt_id", 16'(if0.gnt_id), 16'd5);
    for (int i = 0; i < 3; i++) applyStimulus(8'h20, 1'b1);
    checkOutput("single_hold", 16'(if0.gnt), 16'h0020);
    applyStimulus(8'h00, 1'b1);
    checkOutput("single_release", 16'(if0.gnt), 16'h0000);

    applyStimulus(8'h40, 1'b1);
    checkOutput("wrap_gnt6", 16'(if0.gnt), 16'h0040);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h41, 1'b1);
    checkOutput("wrap_winner0", 16'(if0.gnt_id), 16'd0);
    checkOutput("wrap_gnt0", 16'(if0.gnt), 16'h0001);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h03, 1'b1);
    checkOutput("wrap_ptr1", 16'(if0.gnt), 16'h0002);

    resetPulse();

    for (int k = 0; k < 9; k++) begin
      one_hot = 8'h01 << (k % 8);
      applyStimulus(8'hFF, 1'b1);
      checkOutput($sformatf("rotate_id_%0d", k), 16'(if0.gnt_id), 16'(k % 8));
      checkOutput($sformatf("rotate_gnt_%0d", k), 16'(if0.gnt), 16'(one_hot));
      applyStimulus(8'hFF & ~one_hot, 1'b1);
      checkOutput($sformatf("rotate_gap_%0d", k), 16'(if0.gnt_valid), 16'd0);
    end

    resetPulse();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'h81, 1'b1);
      checkOutput($sformatf("hold3_gnt_%0d", i), 16'(if1.gnt), 16'(exp_to_g[i]));
      checkOutput($sformatf("hold3_timeout_%0d", i), 16'(if1.timeout), 16'(exp_to_t[i]));
    end

    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h04, 1'b0);
      checkOutput("en_low_no_gnt", 16'(if0.gnt), 16'h0000);
    end
    applyStimulus(8'h04, 1'b1);
    checkOutput("en_high_gnt", 16'(if0.gnt), 16'h0004);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h05, 1'b0);
      checkOutput("no_preempt", 16'(if0.gnt), 16'h0004);
    end
    applyStimulus(8'h01, 1'b0);
    checkOutput("en_low_release", 16'(if0.gnt), 16'h0000);
    applyStimulus(8'h01, 1'b0);
    checkOutput("en_low_stay_idle", 16'(if0.gnt), 16'h0000);

    resetPulse();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 249) == 0) resetPulse();
      rv = req_s;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 15) == 0) rv[b] = ~rv[b];
      end
      applyStimulus(rv, ($urandom_range(0, 9) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
